// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer slice.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam logic [2:0] FS_OFF  = 3'b000;
  localparam logic [2:0] FS_SLOW = 3'b001;
  localparam logic [2:0] FS_MED  = 3'b011;
  localparam logic [2:0] FS_FAST = 3'b111;

  localparam logic [4:0] HH_MAX = 5'd23;
  localparam logic [5:0] MM_MAX = 6'd59;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One escalation step; anything past medium saturates at fast.
  function automatic logic [2:0] flowStep(input logic [2:0] fs);
    if (fs == FS_SLOW) return FS_MED;
    return FS_FAST;
  endfunction

endpackage

// File: rtl/alarm_sequencer_sec_timer.sv
// sec_timer: loadable/clearable seconds counter; o_done flags the tick that reaches i_limit.
module sec_timer #(
  parameter int WIDTH = 9
) (
  input  logic             I_CLK,
  input  logic             Rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_countInc;

  assign w_countInc = r_count + WIDTH'(1);
  assign o_done     = i_tick && (w_countInc >= i_limit);

  always_ff @(posedge I_CLK) begin
    if (!Rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_tick) begin
      r_count <= w_countInc;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm-time compare, ring/snooze FSM and flowspeed escalation.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int ESC_SEC    = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       I_CLK,
  input  logic       Rst,
  input  logic       sec_tick,
  input  logic       arm_en,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic       set_we,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic [2:0] flowspeed,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic [4:0] alm_hh,
  output logic [5:0] alm_mm,
  output logic       set_err
);

  localparam int CW = $clog2(maxOf(SNOOZE_SEC, RING_SEC) + 1);
  localparam logic [CW-1:0] RING_LIM = CW'(RING_SEC);
  localparam logic [CW-1:0] ESC_LIM  = CW'(ESC_SEC);

  alarm_state_t r_state;
  alarm_state_t w_nextState;
  logic [2:0]   r_flow;
  logic [2:0]   w_nextFlow;
  logic         r_ringing;
  logic         r_match;
  logic         r_matchPrev;
  logic         r_setErr;
  logic [4:0]   r_almHh;
  logic [5:0]   r_almMm;
  logic         w_matchRise;
  logic         w_setOk;
  logic         w_snzAccept;
  logic         w_snzDone;
  logic         w_ringTick;
  logic         w_enterRing;
  logic         w_escDone;
  logic         w_ringDone;

  assign w_matchRise = r_match && !r_matchPrev;
  assign w_setOk     = (set_hh <= HH_MAX) && (set_mm <= MM_MAX);
  assign w_enterRing = (w_nextState == RINGING) && (r_state != RINGING);
  // A tick that arrives with an accepted button belongs to the new state.
  assign w_ringTick  = sec_tick && (r_state == RINGING) && !stop_btn && !w_snzAccept;

  sec_timer #(.WIDTH(CW)) u_escTimer (
    .I_CLK     (I_CLK),
    .Rst       (Rst),
    .i_clr     (w_enterRing || w_escDone),
    .i_load    (1'b0),
    .i_loadVal ('0),
    .i_tick    (w_ringTick),
    .i_limit   (ESC_LIM),
    .o_done    (w_escDone)
  );

  sec_timer #(.WIDTH(CW)) u_ringTimer (
    .I_CLK     (I_CLK),
    .Rst       (Rst),
    .i_clr     (w_enterRing),
    .i_load    (1'b0),
    .i_loadVal ('0),
    .i_tick    (w_ringTick),
    .i_limit   (RING_LIM),
    .o_done    (w_ringDone)
  );

`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] SNZ_LIM = CW'(SNOOZE_SEC);
  localparam logic [1:0]    CNT_MAX = 2'(MAX_SNOOZE);

  logic          r_snoozing;
  logic [1:0]    r_snoozeCnt;
  logic          w_snzTick;
  logic [CW-1:0] w_snzLoadVal;

  assign w_snzAccept  = arm_en && (r_state == RINGING) && snooze_btn && !stop_btn
                        && (r_snoozeCnt < CNT_MAX);
  assign w_snzTick    = sec_tick && (r_state == SNOOZE) && !stop_btn;
  assign w_snzLoadVal = sec_tick ? CW'(1) : '0;

  sec_timer #(.WIDTH(CW)) u_snoozeTimer (
    .I_CLK     (I_CLK),
    .Rst       (Rst),
    .i_clr     (1'b0),
    .i_load    (w_snzAccept),
    .i_loadVal (w_snzLoadVal),
    .i_tick    (w_snzTick),
    .i_limit   (SNZ_LIM),
    .o_done    (w_snzDone)
  );

  always_ff @(posedge I_CLK) begin
    if (!Rst) begin
      r_snoozing  <= 1'b0;
      r_snoozeCnt <= 2'b00;
    end else begin
      r_snoozing <= (w_nextState == SNOOZE);
      if ((w_nextState == ARMED) || (w_nextState == IDLE)) begin
        r_snoozeCnt <= 2'b00;
      end else if (w_snzAccept) begin
        r_snoozeCnt <= r_snoozeCnt + 2'd1;
      end
    end
  end

  assign snoozing   = r_snoozing;
  assign snooze_cnt = r_snoozeCnt;
`else
  logic w_unusedSnooze;

  assign w_unusedSnooze = snooze_btn;
  assign w_snzAccept    = 1'b0;
  assign w_snzDone      = 1'b0;
  assign snoozing       = 1'b0;
  assign snooze_cnt     = 2'b00;
`endif

  always_ff @(posedge I_CLK) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (!arm_en) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_nextState = ARMED;
        ARMED:   if (w_matchRise) w_nextState = RINGING;
        RINGING: begin
          if (stop_btn)         w_nextState = ARMED;
          else if (w_snzAccept) w_nextState = SNOOZE;
          else if (w_ringDone)  w_nextState = ARMED;
        end
        SNOOZE: begin
          if (stop_btn)       w_nextState = ARMED;
          else if (w_snzDone) w_nextState = RINGING;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    w_nextFlow = FS_OFF;
    if (w_nextState == RINGING) begin
      if (r_state != RINGING) w_nextFlow = FS_SLOW;
      else if (w_escDone)     w_nextFlow = flowStep(r_flow);
      else                    w_nextFlow = r_flow;
    end
  end

  // Outputs and the match pipeline are all registered off the next state.
  always_ff @(posedge I_CLK) begin
    if (!Rst) begin
      r_flow      <= FS_OFF;
      r_ringing   <= 1'b0;
      r_match     <= 1'b0;
      r_matchPrev <= 1'b0;
      r_setErr    <= 1'b0;
      r_almHh     <= '0;
      r_almMm     <= '0;
    end else begin
      r_flow      <= w_nextFlow;
      r_ringing   <= (w_nextState == RINGING);
      r_match     <= (cur_hh == r_almHh) && (cur_mm == r_almMm);
      r_matchPrev <= r_match;
      r_setErr    <= set_we && !w_setOk;
      if (set_we && w_setOk) begin
        r_almHh <= set_hh;
        r_almMm <= set_mm;
      end
    end
  end

  assign flowspeed = r_flow;
  assign ringing   = r_ringing;
  assign alm_hh    = r_almHh;
  assign alm_mm    = r_almMm;
  assign set_err   = r_setErr;

endmodule
